// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem -- word-organised data memory for the memory stage of the pipeline.
//
// Purpose:
//   DEPTH_WORDS x 32-bit storage with byte, halfword and word stores.
//   Loads return the raw addressed word; sign/zero extension and byte
//   selection happen downstream, using byte_off.
//   Misaligned or out-of-range accesses raise address-error flags.
//   A store that raises an address error is suppressed.
//   Every committed store produces a one-cycle registered write-trace pulse.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset (clears memory and trace)
//   addr      in   [31:0] byte address
//   wdata     in   [31:0] right-aligned store data
//   st_op     in   [1:0]  00 none, 01 sw, 10 sh, 11 sb
//   ld_op     in   [1:0]  00 none, 01 lw, 10 lh, 11 lb (alignment check only)
//   pc        in   [31:0] PC of the memory-stage instruction, for the trace
//   rd_word   out  [31:0] raw addressed word (0 when out of range)
//   byte_off  out  [1:0]  addr[1:0]
//   exc_adel  out  load address error
//   exc_ades  out  store address error
//   wt_valid  out  trace pulse, one cycle per committed store
//   wt_pc     out  [31:0] PC of the last committed store
//   wt_addr   out  [31:0] word-aligned address of the last committed store
//   wt_data   out  [31:0] full merged word after the last committed store
// ---------------------------------------------------------------------------
module data_mem #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  st_op,
    input  logic [1:0]  ld_op,
    input  logic [31:0] pc,
    output logic [31:0] rd_word,
    output logic [1:0]  byte_off,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        wt_valid,
    output logic [31:0] wt_pc,
    output logic [31:0] wt_addr,
    output logic [31:0] wt_data
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    // One past the last valid byte address, widened so 4*DEPTH_WORDS never wraps.
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

    // Alignment rule shared by loads and stores (same encoding for both ops).
    function automatic logic is_aligned(input logic [1:0] op, input logic [1:0] lo);
        logic ok;
        case (op)
            2'b01:   ok = (lo == 2'b00);
            2'b10:   ok = (lo[0] == 1'b0);
            2'b11:   ok = 1'b1;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Merge right-aligned store data into the old word according to the store size.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [1:0]  op,
                                                input logic [1:0]  lo);
        logic [31:0] w;
        w = old_word;
        case (op)
            2'b01: w = data;
            2'b10: begin
                if (lo[1]) begin
                    w[31:16] = data[15:0];
                end else begin
                    w[15:0] = data[15:0];
                end
            end
            2'b11:   w[{lo, 3'b000} +: 8] = data[7:0];
            default: w = old_word;
        endcase
        return w;
    endfunction

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic [AW-1:0] idx_s;
    logic          in_range_s;
    logic [31:0]   old_word_s;
    logic [31:0]   merged_s;
    logic          commit_s;

    assign idx_s      = addr[AW+1:2];
    assign in_range_s = ({1'b0, addr} < BYTE_LIMIT);
    assign old_word_s = mem_r[idx_s];
    assign byte_off   = addr[1:0];

    // Address-error flags, read data and store-merge/commit decision.
    always_comb begin
        exc_adel = 1'b0;
        exc_ades = 1'b0;
        rd_word  = 32'h0;
        merged_s = old_word_s;
        commit_s = 1'b0;
        if (ld_op != 2'b00) begin
            exc_adel = !is_aligned(ld_op, addr[1:0]) || !in_range_s;
        end else begin
            exc_adel = 1'b0;
        end
        if (st_op != 2'b00) begin
            exc_ades = !is_aligned(st_op, addr[1:0]) || !in_range_s;
        end else begin
            exc_ades = 1'b0;
        end
        if (in_range_s) begin
            rd_word = old_word_s;
        end else begin
            rd_word = 32'h0;
        end
        merged_s = merge_store(old_word_s, wdata, st_op, addr[1:0]);
        commit_s = (st_op != 2'b00) && !exc_ades;
    end

    // Memory array: cleared while reset is high, otherwise written by committed stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h0;
            end
        end else if (commit_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Write trace: pulse per commit; payload holds its value between commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wt_valid <= 1'b0;
            wt_pc    <= 32'h0;
            wt_addr  <= 32'h0;
            wt_data  <= 32'h0;
        end else begin
            wt_valid <= commit_s;
            if (commit_s) begin
                wt_pc   <= pc;
                wt_addr <= {addr[31:2], 2'b00};
                wt_data <= merged_s;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  st_op;
    logic [1:0]  ld_op;
    logic [31:0] pc;
    logic [31:0] rd_word;
    logic [1:0]  byte_off;
    logic        exc_adel;
    logic        exc_ades;
    logic        wt_valid;
    logic [31:0] wt_pc;
    logic [31:0] wt_addr;
    logic [31:0] wt_data;

    data_mem #(.DEPTH_WORDS(4096)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .st_op    (st_op),
        .ld_op    (ld_op),
        .pc       (pc),
        .rd_word  (rd_word),
        .byte_off (byte_off),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades),
        .wt_valid (wt_valid),
        .wt_pc    (wt_pc),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_t;

    trace_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     done   = 1'b0;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_W    = 2'b01;
    localparam logic [1:0] OP_H    = 2'b10;
    localparam logic [1:0] OP_B    = 2'b11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] st, input logic [1:0] ld, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] p);
        st_op = st;
        ld_op = ld;
        addr  = a;
        wdata = wd;
        pc    = p;
    endtask

    task automatic expect_trace(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
        trace_t t;
        t.pc   = p;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    // Monitor: every trace pulse must match the oldest expected trace.
    initial begin
        trace_t t;
        while (!done) begin
            @(posedge clk);
            #1;
            if (wt_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trace actual pc=%h addr=%h data=%h required no pulse",
                             wt_pc, wt_addr, wt_data);
                end else begin
                    t = exp_q.pop_front();
                    chk("trace_pc", wt_pc, t.pc);
                    chk("trace_addr", wt_addr, t.addr);
                    chk("trace_data", wt_data, t.data);
                end
            end
        end
    end

    // Load alignment vectors: {ld_op, addr, expected exc_adel}.
    logic [1:0]  lv_op  [5] = '{OP_H, OP_B, OP_W, OP_H, OP_W};
    logic [31:0] lv_addr[5] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h3FFC};
    logic        lv_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        reset = 1'b1;
        drive(OP_NONE, OP_NONE, 32'h10, 32'h0, 32'h0);

        // Reset state.
        @(negedge clk); #1;
        chk("reset_rd_word", rd_word, 32'h0);
        chk("reset_wt_valid", {31'h0, wt_valid}, 32'h0);
        chk("reset_wt_pc", wt_pc, 32'h0);
        chk("reset_wt_addr", wt_addr, 32'h0);
        chk("reset_wt_data", wt_data, 32'h0);

        // sw presented as reset deasserts; commits at the first edge with reset low.
        @(negedge clk);
        reset = 1'b0;
        drive(OP_W, OP_NONE, 32'h10, 32'h11223344, 32'h100);
        expect_trace(32'h100, 32'h10, 32'h11223344);
        #1;
        chk("sw_same_cycle_old", rd_word, 32'h0);
        chk("sw_ades", {31'h0, exc_ades}, 32'h0);

        @(negedge clk);
        drive(OP_B, OP_NONE, 32'h12, 32'h000000AB, 32'h104);
        expect_trace(32'h104, 32'h10, 32'h11AB3344);
        #1;
        chk("sw_readback", rd_word, 32'h11223344);
        chk("byte_off_12", {30'h0, byte_off}, 32'h2);
        chk("wt_valid_pulse", {31'h0, wt_valid}, 32'h1);

        // Upper wdata bits are junk and must be ignored by sh.
        @(negedge clk);
        drive(OP_H, OP_NONE, 32'h10, 32'hFFFFBEEF, 32'h108);
        expect_trace(32'h108, 32'h10, 32'h11ABBEEF);
        #1;
        chk("sb_readback", rd_word, 32'h11AB3344);

        // Misaligned sw: faults, no write, no trace.
        @(negedge clk);
        drive(OP_W, OP_NONE, 32'h6, 32'hCAFEF00D, 32'h10C);
        #1;
        chk("sw_misaligned_ades", {31'h0, exc_ades}, 32'h1);
        chk("sw_misaligned_adel", {31'h0, exc_adel}, 32'h0);

        @(negedge clk);
        drive(OP_NONE, OP_NONE, 32'h4, 32'h0, 32'h0);
        #1;
        chk("word4_unchanged", rd_word, 32'h0);
        chk("fault_wt_valid", {31'h0, wt_valid}, 32'h0);
        chk("fault_wt_data_hold", wt_data, 32'h11ABBEEF);
        chk("fault_wt_pc_hold", wt_pc, 32'h108);

        // Load alignment table (no stores, so crossing an edge is harmless).
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ld_op = lv_op[i];
            addr  = lv_addr[i];
            #1;
            chk($sformatf("load_align_%0d", i), {31'h0, exc_adel}, {31'h0, lv_exp[i]});
        end

        // Out-of-range sw with an lw in the same cycle: both flags.
        @(negedge clk);
        drive(OP_W, OP_W, 32'h4000, 32'hDEADBEEF, 32'h110);
        #1;
        chk("oor_ades", {31'h0, exc_ades}, 32'h1);
        chk("oor_adel", {31'h0, exc_adel}, 32'h1);
        chk("oor_rd_word", rd_word, 32'h0);

        @(negedge clk);
        drive(OP_NONE, OP_NONE, 32'h0, 32'h0, 32'h0);
        #1;
        chk("oor_no_wrap_write", rd_word, 32'h0);

        // Store into the last halfword of memory.
        @(negedge clk);
        drive(OP_H, OP_NONE, 32'h3FFE, 32'h00001234, 32'h200);
        expect_trace(32'h200, 32'h3FFC, 32'h12340000);
        #1;
        chk("top_sh_ades", {31'h0, exc_ades}, 32'h0);

        // Misaligned lw alongside a legal sb: store still commits.
        @(negedge clk);
        drive(OP_B, OP_W, 32'h13, 32'h00000077, 32'h204);
        expect_trace(32'h204, 32'h10, 32'h77ABBEEF);
        #1;
        chk("mixed_adel", {31'h0, exc_adel}, 32'h1);
        chk("mixed_ades", {31'h0, exc_ades}, 32'h0);
        chk("byte_off_13", {30'h0, byte_off}, 32'h3);

        @(negedge clk);
        drive(OP_W, OP_NONE, 32'h20, 32'h5, 32'h208);
        expect_trace(32'h208, 32'h20, 32'h5);
        #1;
        chk("rdw_old_0x20", rd_word, 32'h0);

        // New value visible next cycle, then reset mid-cycle cancels a pending store.
        @(negedge clk);
        drive(OP_NONE, OP_NONE, 32'h20, 32'h0, 32'h0);
        #1;
        chk("rdw_new_0x20", rd_word, 32'h5);
        chk("pre_reset_wt_valid", {31'h0, wt_valid}, 32'h1);
        drive(OP_W, OP_NONE, 32'h24, 32'h99, 32'h20C);
        #1;
        reset = 1'b1;
        #1;
        chk("async_wt_valid", {31'h0, wt_valid}, 32'h0);
        addr = 32'h20;
        #1;
        chk("async_rd_word", rd_word, 32'h0);

        @(negedge clk);
        drive(OP_NONE, OP_NONE, 32'h24, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("cancel_rd_word", rd_word, 32'h0);
        chk("cancel_wt_valid", {31'h0, wt_valid}, 32'h0);
        chk("cancel_wt_data", wt_data, 32'h0);

        repeat (2) @(negedge clk);
        chk("trace_queue_drained", exp_q.size(), 32'h0);
        done = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
